// File: rtl/spi_upl_pkg.sv
// spi_upl_pkg: shared state encodings, command opcodes and header layout for the SPI frame uploader
package spi_upl_pkg;
  localparam int IDLE_I = 0;
  localparam int ARMED_I = 1;
  localparam int STREAM_I = 2;
  localparam int EXHAUST_I = 3;
  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_ARMED = 4'b0010;
  localparam logic [3:0] ST_STREAM = 4'b0100;
  localparam logic [3:0] ST_EXHAUST = 4'b1000;
  typedef enum logic [3:0] {
    CODE_IDLE = 4'd0,
    CODE_ARMED = 4'd1,
    CODE_STREAM = 4'd2,
    CODE_EXHAUST = 4'd3,
    CODE_UNDERRUN = 4'd4
  } state_code_e;
  localparam logic [7:0] CMD_BURST = 8'h01;
  localparam logic [7:0] CMD_SETW = 8'h02;
  localparam logic [7:0] HDR_MAGIC = 8'hA6;
  localparam logic [31:0] HDR_SYNC = 32'hFFFFFF7F;
  localparam int HDR_CNT_LSB = 48;
  localparam int HDR_SEQ_LSB = 40;
  localparam int HDR_CODE_LSB = 36;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchroniser with either-polarity edge pulse
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic pulse
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign level = sync_q[STAGES-1];
  assign pulse = sync_q[STAGES-1] ^ prev_q;
endmodule

// File: rtl/spi_frame_uploader.sv
// spi_frame_uploader: decodes host commands and streams buffered frames or status headers to the SPI shifter
module spi_frame_uploader
  import spi_upl_pkg::*;
#(
  parameter int FRAME_BITS = 128,
  parameter int BUFFLENLOG2 = 9,
  parameter int SYNC_STAGES = 2,
  parameter int SWAP_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [1:0]             Width,
  input  logic [FRAME_BITS-1:0]  Frame,
  output logic                   FrameNext,
  input  logic                   FrameReady,
  input  logic [BUFFLENLOG2-1:0] FramesCnt,
  output logic [FRAME_BITS-1:0]  TxPacket,
  input  logic                   TxGetNext,
  input  logic [31:0]            RxPacket,
  input  logic                   PktComplete,
  input  logic                   CS,
  output logic [15:0]            Underruns
);
  logic cs_hi, get_edge, rx_edge, cs_edge_unused;
  logic [3:0] state_q, state_d;
  logic [1:0] width_q, width_d;
  logic [15:0] send_count_q, send_count_d, underruns_q, underruns_d, n, frames_cnt;
  logic [7:0] seq_q, seq_d;
  logic frame_next_q, frame_next_d, is_burst, is_setw, go;
  logic [5:0] rx_unused;
  logic [FRAME_BITS-1:0] frame_fmt, header;
  state_code_e code;
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs (.clk(clk), .rst(rst), .din(CS), .level(cs_hi), .pulse(cs_edge_unused));
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_get (.clk(clk), .rst(rst), .din(TxGetNext), .level(), .pulse(get_edge));
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_rx (.clk(clk), .rst(rst), .din(PktComplete), .level(), .pulse(rx_edge));
  assign n = RxPacket[15:0];
  assign rx_unused = RxPacket[23:18];
  assign is_burst = RxPacket[31:24] == CMD_BURST;
  assign is_setw = RxPacket[31:24] == CMD_SETW;
  assign frames_cnt = 16'(FramesCnt);
  assign go = !cs_hi && get_edge;
  for (genvar l = 0; l < FRAME_BITS / 16; l++) begin : g_lane
    assign frame_fmt[16*l +: 16] = (SWAP_BYTES != 0) ? {Frame[16*l +: 8], Frame[16*l+8 +: 8]} : Frame[16*l +: 16];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q[IDLE_I]) state_d = (!cs_hi && rx_edge) ? ST_ARMED : ST_IDLE;
    else if (cs_hi) state_d = ST_IDLE;
    else if (state_q[ARMED_I] && get_edge)
      state_d = (is_burst && n != 16'd0 && !(FrameReady && n == 16'd1)) ? ST_STREAM : ST_EXHAUST;
    else if (state_q[STREAM_I] && get_edge && FrameReady && send_count_q == 16'd1) state_d = ST_EXHAUST;
  end
  always_comb begin
    width_d = width_q;
    seq_d = seq_q;
    send_count_d = send_count_q;
    underruns_d = underruns_q;
    frame_next_d = 1'b0;
    if (state_q[IDLE_I]) send_count_d = frames_cnt;
    else if (go && state_q[ARMED_I]) begin
      width_d = (is_burst || is_setw) ? RxPacket[17:16] : width_q;
      seq_d = is_burst ? seq_q + 8'd1 : seq_q;
      frame_next_d = is_burst && n != 16'd0 && FrameReady;
      // a pop on entry already counts as the first of the n frames
      send_count_d = !is_burst ? send_count_q : n == 16'd0 ? frames_cnt : !FrameReady ? n :
                     n == 16'd1 ? frames_cnt : n - 16'd1;
    end else if (go && state_q[STREAM_I]) begin
      frame_next_d = FrameReady;
      send_count_d = !FrameReady ? send_count_q : send_count_q == 16'd1 ? frames_cnt : send_count_q - 16'd1;
      underruns_d = (FrameReady || underruns_q == 16'hFFFF) ? underruns_q : underruns_q + 16'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q <= 2'd3;
      seq_q <= 8'd0;
      send_count_q <= 16'd0;
      underruns_q <= 16'd0;
      frame_next_q <= 1'b0;
    end else begin
      width_q <= width_d;
      seq_q <= seq_d;
      send_count_q <= send_count_d;
      underruns_q <= underruns_d;
      frame_next_q <= frame_next_d;
    end
  end
  always_comb begin
    code = state_q[STREAM_I] ? (FrameReady ? CODE_STREAM : CODE_UNDERRUN) :
           state_q[ARMED_I] ? CODE_ARMED : state_q[EXHAUST_I] ? CODE_EXHAUST : CODE_IDLE;
    header = '0;
    header[FRAME_BITS-1 -: 8] = HDR_MAGIC;
    header[HDR_CNT_LSB +: 16] = send_count_q;
    header[HDR_SEQ_LSB +: 8] = seq_q;
    header[HDR_CODE_LSB +: 4] = code;
    header[31:0] = HDR_SYNC;
    TxPacket = (state_q[STREAM_I] && FrameReady) ? frame_fmt : header;
  end
  assign Width = width_q;
  assign FrameNext = frame_next_q;
  assign Underruns = underruns_q;
endmodule

// File: tb/tb_spi_frame_uploader.sv
// tb_spi_frame_uploader: directed vector table plus hand sequences for underrun, swap, CS abort, seq wrap and reset
module tb_spi_frame_uploader;
  localparam int FB = 128;
  localparam int BL = 9;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] width, width_ns;
  logic [FB-1:0] frame, tx, tx_ns, swapped;
  logic frame_next, frame_next_ns;
  logic frame_ready = 1'b1;
  logic [BL-1:0] frames_cnt = '0;
  logic tx_get_next = 1'b0;
  logic [31:0] rx_packet = '0;
  logic pkt_complete = 1'b0;
  logic cs = 1'b0;
  logic [15:0] underruns, underruns_ns;
  logic [7:0] exp_seq;
  int n_tests = 0;
  int n_fail = 0;
  int pops = 0;
  int p0, lat;
  typedef struct {
    logic [31:0] rx;
    logic [8:0]  fc;
    int          gets;
    logic [1:0]  w;
    int          npop;
    logic [3:0]  code;
    logic [15:0] cnt;
    logic [7:0]  seq;
  } vec_t;
  vec_t vecs[6];

  spi_frame_uploader #(.FRAME_BITS(FB), .BUFFLENLOG2(BL), .SYNC_STAGES(SS), .SWAP_BYTES(1)) dut (
    .clk(clk), .rst(rst), .Width(width), .Frame(frame), .FrameNext(frame_next), .FrameReady(frame_ready),
    .FramesCnt(frames_cnt), .TxPacket(tx), .TxGetNext(tx_get_next), .RxPacket(rx_packet),
    .PktComplete(pkt_complete), .CS(cs), .Underruns(underruns));
  spi_frame_uploader #(.FRAME_BITS(FB), .BUFFLENLOG2(BL), .SYNC_STAGES(SS), .SWAP_BYTES(0)) dut_ns (
    .clk(clk), .rst(rst), .Width(width_ns), .Frame(frame), .FrameNext(frame_next_ns), .FrameReady(frame_ready),
    .FramesCnt(frames_cnt), .TxPacket(tx_ns), .TxGetNext(tx_get_next), .RxPacket(rx_packet),
    .PktComplete(pkt_complete), .CS(cs), .Underruns(underruns_ns));

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_next) pops++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic do_get();
    tx_get_next = ~tx_get_next;
    tick(6);
  endtask
  task automatic session(input logic [31:0] rx, input logic [8:0] fc);
    cs = 1'b1;
    tick(5);
    frames_cnt = fc;
    cs = 1'b0;
    tick(5);
    rx_packet = rx;
    pkt_complete = ~pkt_complete;
    tick(5);
  endtask

  initial begin
    frame = 128'h0011_2233_4455_6677_8899_AABB_CCDD_1234;
    for (int i = 0; i < FB / 16; i++) swapped[16*i +: 16] = {frame[16*i +: 8], frame[16*i+8 +: 8]};
    vecs[0] = '{32'h0103_0004, 9'd10, 5, 2'd3, 4, 4'd3, 16'd10, 8'd1};
    vecs[1] = '{32'h0102_0000, 9'd7, 1, 2'd2, 0, 4'd3, 16'd7, 8'd2};
    vecs[2] = '{32'h0201_0009, 9'd5, 1, 2'd1, 0, 4'd3, 16'd5, 8'd2};
    vecs[3] = '{32'h0700_0003, 9'd4, 1, 2'd1, 0, 4'd3, 16'd4, 8'd2};
    vecs[4] = '{32'h0100_0002, 9'd9, 1, 2'd0, 1, 4'd4, 16'd1, 8'd3};
    vecs[5] = '{32'h0101_0001, 9'd6, 2, 2'd1, 1, 4'd3, 16'd6, 8'd4};
    tick(3);
    check("reset header", tx, 128'hA600_0000_0000_0000_0000_0000_FFFF_FF7F);
    check("reset width", width, 2'd3);
    check("reset framenext", frame_next, 1'b0);
    check("reset underruns", underruns, 16'd0);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      p0 = pops;
      session(vecs[i].rx, vecs[i].fc);
      for (int g = 0; g < vecs[i].gets; g++) do_get();
      frame_ready = 1'b0;
      tick(1);
      check($sformatf("v%0d width", i), width, vecs[i].w);
      check($sformatf("v%0d pops", i), pops - p0, vecs[i].npop);
      check($sformatf("v%0d code", i), tx[39:36], vecs[i].code);
      check($sformatf("v%0d count", i), tx[63:48], vecs[i].cnt);
      check($sformatf("v%0d seq", i), tx[47:40], vecs[i].seq);
      check($sformatf("v%0d magic", i), tx[127:120], 8'hA6);
      frame_ready = 1'b1;
    end
    p0 = pops;
    session(32'h0103_0003, 9'd8);
    do_get();
    frame_ready = 1'b0;
    tick(1);
    check("underrun code", tx[39:36], 4'd4);
    check("underrun count", tx[63:48], 16'd2);
    do_get();
    check("underrun counter", underruns, 16'd1);
    check("underrun no pop", pops - p0, 1);
    frame_ready = 1'b1;
    do_get();
    do_get();
    check("underrun total pops", pops - p0, 3);
    check("underrun exhaust code", tx[39:36], 4'd3);
    check("underrun exhaust count", tx[63:48], 16'd8);
    check("underrun counter held", underruns, 16'd1);
    p0 = pops;
    session(32'h0100_0005, 9'd12);
    tx_get_next = ~tx_get_next;
    lat = 0;
    while (!frame_next && lat < 10) begin
      tick(1);
      lat++;
    end
    check("pop latency", lat, SS + 1);
    tick(4);
    check("swap frame", tx, swapped);
    check("swap lane0", tx[15:0], 16'h3412);
    check("noswap frame", tx_ns, frame);
    check("noswap lane0", tx_ns[15:0], 16'h1234);
    cs = 1'b1;
    tx_get_next = ~tx_get_next;
    tick(6);
    check("cs abort pops", pops - p0, 1);
    check("cs abort idle code", tx[39:36], 4'd0);
    check("cs abort seq", tx[47:40], 8'd6);
    exp_seq = 8'd6;
    while (exp_seq != 8'd255) begin
      session(32'h0100_0000, 9'd3);
      do_get();
      exp_seq++;
    end
    check("seq 255", tx[47:40], 8'd255);
    session(32'h0100_0000, 9'd3);
    do_get();
    check("seq wrap", tx[47:40], 8'd0);
    check("seq wrap width", width, 2'd0);
    session(32'h0102_0006, 9'd4);
    do_get();
    frame_ready = 1'b0;
    tick(1);
    check("pre-reset stream code", tx[39:36], 4'd4);
    frame_ready = 1'b1;
    #2;
    rst = 1'b1;
    tx_get_next = 1'b0;
    pkt_complete = 1'b0;
    #1;
    check("midreset width", width, 2'd3);
    check("midreset framenext", frame_next, 1'b0);
    check("midreset sync", tx[31:0], 32'hFFFF_FF7F);
    check("midreset code", tx[39:36], 4'd0);
    check("midreset seq", tx[47:40], 8'd0);
    check("midreset underruns", underruns, 16'd0);
    tick(3);
    rst = 1'b0;
    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
